// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus and issues a request-to-send. It then shifts out
// {stop, odd parity, data[7:0]}, LSB first, on device clock falls, and checks the device ACK.
// Optional feature macro: PS2_TX_RETRY_EN. When it is defined, a NACK or timeout
// restarts the transfer up to RETRY_MAX times before tx_err is reported.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int RETRY_MAX      = 2
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_low,
    output logic       ps2_data_low
);

`ifdef PS2_TX_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif
    localparam int RETRY_LIMIT = RETRY_EN ? RETRY_MAX : 0;
    localparam int RETRY_W     = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;

    localparam int PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
    localparam logic [PH_W-1:0] RTS_LAST = PH_W'(RTS_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t               state;
    logic [2:0]           clk_sync;
    logic [2:0]           data_sync;
    logic [PH_W-1:0]      ph_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic [3:0]           bit_cnt;
    logic [9:0]           frame;
    logic [9:0]           frame_init;
    logic [RETRY_W-1:0]   retry_cnt;

    logic                 fall;
    logic                 line_idle;
    logic                 watchdog;
    logic                 retry_ok;
    logic                 fail_req;
    logic [1:0]           fail_code;

    assign fall      = clk_sync[2] & ~clk_sync[1];
    assign line_idle = clk_sync[1] & data_sync[1];
    assign watchdog  = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
    assign retry_ok  = RETRY_EN && (retry_cnt != RETRY_W'(RETRY_LIMIT));

    // Pad synchronizers; reset to the idle-high level so release never looks like a fall.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    // Failure detection: device NACK at the ACK fall, or no device fall within the timeout window.
    always_comb begin
        fail_req  = 1'b0;
        fail_code = 2'b00;
        if (state == ACK && fall && data_sync[1]) begin
            fail_req  = 1'b1;
            fail_code = ERR_NACK;
        end else if (watchdog && !fall && !(state == WAIT_IDLE && line_idle)
                     && to_cnt == TO_LAST) begin
            fail_req  = 1'b1;
            fail_code = ERR_TIMEOUT;
        end
    end

    // Transfer FSM with registered line drives and status outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state        <= IDLE;
            ph_cnt       <= '0;
            to_cnt       <= '0;
            bit_cnt      <= '0;
            frame        <= '1;
            frame_init   <= '1;
            retry_cnt    <= '0;
            tx_ready     <= 1'b1;
            busy         <= 1'b0;
            tx_done      <= 1'b0;
            tx_err       <= 1'b0;
            err_code     <= 2'b00;
            ps2_clk_low  <= 1'b0;
            ps2_data_low <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;

            if (!watchdog || fall) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_LAST) begin
                to_cnt <= to_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        frame       <= {1'b1, ~^tx_data, tx_data};
                        frame_init  <= {1'b1, ~^tx_data, tx_data};
                        retry_cnt   <= '0;
                        ph_cnt      <= '0;
                        ps2_clk_low <= 1'b1;
                        busy        <= 1'b1;
                        tx_ready    <= 1'b0;
                        state       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (ph_cnt == INH_LAST) begin
                        ph_cnt       <= '0;
                        ps2_data_low <= 1'b1;
                        state        <= RTS;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                RTS: begin
                    if (ph_cnt == RTS_LAST) begin
                        ph_cnt      <= '0;
                        bit_cnt     <= '0;
                        ps2_clk_low <= 1'b0;
                        state       <= SHIFT;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        ps2_data_low <= ~frame[0];
                        frame        <= {1'b1, frame[9:1]};
                        bit_cnt      <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd9) begin
                            state <= ACK;
                        end
                    end
                end
                ACK: begin
                    if (fall && !data_sync[1]) begin
                        state <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (line_idle) begin
                        tx_done  <= 1'b1;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    ps2_clk_low  <= 1'b0;
                    ps2_data_low <= 1'b0;
                    busy         <= 1'b0;
                    tx_ready     <= 1'b1;
                    state        <= IDLE;
                end
            endcase

            // Failure overrides the per-state update above: release data and either
            // restart the whole handshake from INHIBIT or report and return to IDLE.
            if (fail_req) begin
                ps2_data_low <= 1'b0;
                if (retry_ok) begin
                    retry_cnt   <= retry_cnt + 1'b1;
                    frame       <= frame_init;
                    ph_cnt      <= '0;
                    ps2_clk_low <= 1'b1;
                    state       <= INHIBIT;
                end else begin
                    ps2_clk_low <= 1'b0;
                    busy        <= 1'b0;
                    tx_ready    <= 1'b1;
                    tx_err      <= 1'b1;
                    err_code    <= fail_code;
                    state       <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the DUT.
// A scoreboard holds expected frames and expected outcomes (done / NACK / timeout).
module tb_ps2_host_tx;

    localparam int RES_DONE = 0;
    localparam int RES_NACK = 1;
    localparam int RES_TO   = 2;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_err;
    logic [1:0] err_code;
    logic       ps2_clk, ps2_data;
    logic       ps2_clk_low, ps2_data_low;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    logic [10:0] frame_q[$];
    int          res_q[$];
    logic        prev_ev = 1'b0;

    assign ps2_clk  = ~(ps2_clk_low | dev_clk_low);
    assign ps2_data = ~(ps2_data_low | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .RTS_CYCLES(4),
        .TIMEOUT_CYCLES(200),
        .RETRY_MAX(2)
    ) dut (
        .clk(clk),
        .clrn(clrn),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .tx_done(tx_done),
        .tx_err(tx_err),
        .err_code(err_code),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .ps2_clk_low(ps2_clk_low),
        .ps2_data_low(ps2_data_low)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result monitor: pops expected outcome on every tx_done / tx_err pulse.
    always @(negedge clk) begin
        if (clrn) begin
            if (prev_ev) check("ready_after_result", tx_ready, 1);
            prev_ev <= tx_done | tx_err;
            if (tx_done && tx_err) check("done_err_same_cycle", 1, 0);
            if (tx_done || tx_err) begin
                if (res_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("result", tx_err ? {30'd0, err_code} : 32'd0, res_q.pop_front());
                end
                if (tx_err) begin
                    check("err_clk_released", ps2_clk_low, 0);
                    check("err_data_released", ps2_data_low, 0);
                end
            end
        end else begin
            prev_ev <= 1'b0;
        end
    end

    task automatic send(input logic [7:0] d, input int res, input int nframes);
        @(negedge clk);
        check("ready_before_send", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < nframes; i++) frame_q.push_back({1'b1, ~^d, d, 1'b0});
        if (res >= 0) res_q.push_back(res);
        @(negedge clk);
        tx_valid = 1'b0;
        check("busy_after_send", busy, 1);
        check("ready_after_send", tx_ready, 0);
    endtask

    // Waits for the host to inhibit and then release ps2_clk; optionally checks the hold length.
    task automatic wait_release(input bit chk_len);
        int n;
        n = 0;
        while (!ps2_clk_low && n < 2000) begin @(negedge clk); n++; end
        check("inhibit_seen", ps2_clk_low, 1);
        n = 0;
        while (ps2_clk_low && n < 2000) begin @(negedge clk); n++; end
        if (chk_len) check("clk_low_cycles", n, 24);
    endtask

    // Device side: nfalls bit clocks at 20 cycles/bit, then an ACK clock if the frame completed.
    task automatic dev_xfer(input int nfalls, input bit nack, input bit chk_len,
                            output logic [10:0] cap);
        cap = '1;
        wait_release(chk_len);
        cap[0] = ps2_data;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= nfalls; i++) begin
            dev_clk_low = 1'b1;
            repeat (10) @(negedge clk);
            cap[i] = ps2_data;
            dev_clk_low = 1'b0;
            repeat (10) @(negedge clk);
        end
        if (nfalls == 10) begin
            if (frame_q.size() == 0) check("frame_q_empty", 1, 0);
            else check("frame", cap, frame_q.pop_front());
            if (!nack) dev_data_low = 1'b1;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (5) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_results();
        int n;
        n = 0;
        while (res_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
        check("result_seen", res_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [10:0] cap;
        int m;

        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_clk_low", ps2_clk_low, 0);
        check("rst_data_low", ps2_data_low, 0);
        @(negedge clk);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        // Set-LEDs command, device ACKs.
        send(8'hED, RES_DONE, 1);
        dev_xfer(10, 1'b0, 1'b1, cap);
        check("ed_parity", cap[9], 1);
        wait_results();

`ifndef PS2_TX_RETRY_EN
        // Parity boundaries.
        send(8'h01, RES_DONE, 1);
        dev_xfer(10, 1'b0, 1'b1, cap);
        check("parity_01", cap[9], 0);
        wait_results();
        send(8'hFF, RES_DONE, 1);
        dev_xfer(10, 1'b0, 1'b1, cap);
        check("parity_ff", cap[9], 1);
        wait_results();

        // Device NACK.
        send(8'h5A, RES_NACK, 1);
        dev_xfer(10, 1'b1, 1'b1, cap);
        wait_results();
        repeat (3) @(negedge clk);
        check("nack_code_held", err_code, 1);

        // Device never clocks: timeout counted from SHIFT entry.
        send(8'h12, RES_TO, 0);
        wait_release(1'b1);
        m = 0;
        while (!tx_err && m < 1000) begin @(negedge clk); m++; end
        check("timeout_cycles", m, 200);
        wait_results();
        repeat (3) @(negedge clk);
        check("timeout_code_held", err_code, 2);
`else
        // NACK twice, ACK on the third attempt.
        send(8'hED, RES_DONE, 3);
        dev_xfer(10, 1'b1, 1'b1, cap);
        check("busy_retry1", busy, 1);
        dev_xfer(10, 1'b1, 1'b0, cap);
        check("busy_retry2", busy, 1);
        dev_xfer(10, 1'b0, 1'b0, cap);
        wait_results();
`endif

        // Asynchronous reset after the fourth fall releases both lines at once.
        send(8'h00, -1, 0);
        dev_xfer(4, 1'b0, 1'b1, cap);
        check("mid_shift_data_low", ps2_data_low, 1);
        #2;
        clrn = 1'b0;
        #1;
        check("rst_mid_clk_low", ps2_clk_low, 0);
        check("rst_mid_data_low", ps2_data_low, 0);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", tx_ready, 1);
        check("rst_mid_busy", busy, 0);

        // Send once more after reset to confirm clean recovery.
        send(8'hF4, RES_DONE, 1);
        dev_xfer(10, 1'b0, 1'b1, cap);
        wait_results();

        check("frame_q_drained", frame_q.size(), 0);
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
